// File: rtl/delay_line_pkg.sv
// Shared sizing helpers for the strobed delay line: clog2 and the derived
// pointer / fill-counter widths for a given MAX_DELAY.
package delay_line_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Circular-buffer address width; never narrower than one bit.
  function automatic int ptr_width(input int max_delay);
    return (clog2(max_delay) < 1) ? 1 : clog2(max_delay);
  endfunction

  // Fill counter and delay register both hold 0..MAX_DELAY inclusive.
  function automatic int fill_width(input int max_delay);
    return (clog2(max_delay + 1) < 1) ? 1 : clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample store: synchronous write, combinational read that
// returns the old contents when read and write hit the same slot.
module delay_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/delay_line_strobed.sv
// Runtime-programmable delay line counting valid samples, not clocks.
// Build option DELAY_LINE_PRIME_GATE_EN: suppress output strobes until primed.
module delay_line_strobed
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DELAY   = 64,
  parameter int DELAY_WIDTH = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   input_strobe,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   output_strobe,
  output logic                   primed,
  output logic                   delay_err
);

  localparam int PTR_W  = ptr_width(MAX_DELAY);
  localparam int FILL_W = fill_width(MAX_DELAY);
  localparam int MATH_W = FILL_W + 1;
  localparam logic [DELAY_WIDTH-1:0] MAX_REQ  = DELAY_WIDTH'(MAX_DELAY);
  localparam logic [FILL_W-1:0]      MAX_FILL = FILL_W'(MAX_DELAY);
  localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(MAX_DELAY - 1);
  localparam logic [MATH_W-1:0]      DEPTH_EXT = MATH_W'(MAX_DELAY);

  logic [FILL_W-1:0]     delay_q, delay_d;
  logic [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  delay_err_q, delay_err_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  output_strobe_q, output_strobe_d;

  logic                  accept;
  logic                  delay_change;
  logic [FILL_W-1:0]     delay_clamp;
  logic [MATH_W-1:0]     wr_ext, d_ext;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] sample;

  function automatic logic [FILL_W-1:0] clamp_delay(input logic [DELAY_WIDTH-1:0] req);
    return (req > MAX_REQ) ? MAX_FILL : FILL_W'(req);
  endfunction

  delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DELAY),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clock (clock),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign primed = (fill_cnt_q >= delay_q);

  always_comb begin
    accept       = enable && input_strobe;
    delay_clamp  = clamp_delay(delay);
    delay_change = enable && (delay_clamp != delay_q);

    // Read slot is D samples behind the write pointer, modulo the ring size.
    wr_ext = MATH_W'(wr_ptr_q);
    d_ext  = MATH_W'(delay_q);
    if (wr_ext >= d_ext) begin
      rd_ptr = PTR_W'(wr_ext - d_ext);
    end else begin
      rd_ptr = PTR_W'(wr_ext + DEPTH_EXT - d_ext);
    end
    sample = (delay_q == '0) ? data_in : rd_data;

    delay_d     = delay_change ? delay_clamp : delay_q;
    delay_err_d = delay_err_q | (delay > MAX_REQ);

    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    // A delay change re-primes, taking priority over the sample count.
    fill_cnt_d = fill_cnt_q;
    if (delay_change) begin
      fill_cnt_d = '0;
    end else if (accept && (fill_cnt_q != MAX_FILL)) begin
      fill_cnt_d = fill_cnt_q + FILL_W'(1);
    end

`ifdef DELAY_LINE_PRIME_GATE_EN
    output_strobe_d = accept && primed;
    data_out_d      = (accept && primed) ? sample : data_out_q;
`else
    output_strobe_d = accept;
    data_out_d      = accept ? (primed ? sample : '0) : data_out_q;
`endif
  end

  // p0 -> p1: state and registered output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_q         <= '0;
      fill_cnt_q      <= '0;
      wr_ptr_q        <= '0;
      delay_err_q     <= 1'b0;
      data_out_q      <= '0;
      output_strobe_q <= 1'b0;
    end else begin
      delay_q         <= delay_d;
      fill_cnt_q      <= fill_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      delay_err_q     <= delay_err_d;
      data_out_q      <= data_out_d;
      output_strobe_q <= output_strobe_d;
    end
  end

  assign data_out      = data_out_q;
  assign output_strobe = output_strobe_q;
  assign delay_err     = delay_err_q;

endmodule

// File: tb/tb_delay_line_strobed.sv
// Scoreboard bench for delay_line_strobed: a history-based reference model
// predicts each output; a negedge monitor pops and compares.
module tb_delay_line_strobed;

  localparam int DW   = 32;
  localparam int MAXD = 64;
  localparam int DLW  = 7;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [DLW-1:0] delay = '0;
  logic [DW-1:0]  data_in = '0;
  logic           input_strobe = 1'b0;
  logic [DW-1:0]  data_out;
  logic           output_strobe;
  logic           primed;
  logic           delay_err;

  delay_line_strobed #(
    .DATA_WIDTH  (DW),
    .MAX_DELAY   (MAXD),
    .DELAY_WIDTH (DLW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .delay         (delay),
    .data_in       (data_in),
    .input_strobe  (input_strobe),
    .data_out      (data_out),
    .output_strobe (output_strobe),
    .primed        (primed),
    .delay_err     (delay_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hist[$];
  int            d_m = 0;
  int            fill_m = 0;
  bit            err_m = 1'b0;
  int            neg_cnt = 0;
  int            compared = 0;
  int            mismatched = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    d_m    = 0;
    fill_m = 0;
    err_m  = 1'b0;
  endtask

  // Reference: sample n (since reset) leaves as sample n-D, valid once
  // at least D samples have been accepted since the last re-prime.
  task automatic model_edge(input bit en, input bit stb, input logic [DW-1:0] din, input int dly);
    int            clamp;
    bit            pr;
    logic [DW-1:0] v;
    exp_t          e;
    clamp = (dly > MAXD) ? MAXD : dly;
    if (dly > MAXD) err_m = 1'b1;
    if (en && stb) begin
      pr = (fill_m >= d_m);
      v  = '0;
      if (d_m == 0) v = din;
      else if (pr) v = hist[hist.size() - d_m];
      e.tag = neg_cnt + 1;
`ifdef DELAY_LINE_PRIME_GATE_EN
      if (pr) begin
        e.data = v;
        exp_q.push_back(e);
      end
`else
      e.data = pr ? v : '0;
      exp_q.push_back(e);
`endif
      hist.push_back(din);
    end
    if (en) begin
      if (clamp != d_m) begin
        d_m    = clamp;
        fill_m = 0;
      end else if (stb && fill_m < MAXD) begin
        fill_m++;
      end
    end
  endtask

  task automatic step(input bit en, input bit stb, input logic [DW-1:0] din, input int dly);
    enable       = en;
    input_strobe = stb;
    data_in      = din;
    delay        = DLW'(dly);
    @(posedge clock);
    if (reset) model_reset();
    else model_edge(en, stb, din, dly);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    neg_cnt++;
    if (exp_q.size() > 0 && exp_q[0].tag < neg_cnt) begin
      compared++;
      mismatched++;
      $display("FAIL missing_strobe: got none, expected data %0h at cycle %0d", exp_q[0].data, exp_q[0].tag);
      void'(exp_q.pop_front());
    end
    if (output_strobe) begin
      if (exp_q.size() == 0 || exp_q[0].tag != neg_cnt) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_strobe: got strobe data %0h, expected none at cycle %0d", data_out, neg_cnt);
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e.data);
      end
    end
    check("primed", DW'(primed), DW'(fill_m >= d_m));
    check("delay_err", DW'(delay_err), DW'(err_m));
  end

  initial begin
    bit            s;
    logic [DW-1:0] r;
    int            dr;

    #1;
    check("rst_data_out", data_out, '0);
    check("rst_strobe", DW'(output_strobe), '0);
    check("rst_primed", DW'(primed), DW'(1));
    check("rst_delay_err", DW'(delay_err), '0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    reset = 1'b0;

    // Fixed D=16, counting data
    step(1, 0, '0, 16);
    for (int i = 0; i < 40; i++) step(1, 1, DW'(i), 16);

    // D=3, strobe every third cycle, data 10..50
    step(1, 0, '0, 3);
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 0) step(1, 1, DW'(10 * (i / 3 + 1)), 3);
      else step(1, 0, $urandom, 3);
    end
    step(1, 0, '0, 3);
    step(1, 0, '0, 3);

    // D=0 bypass with random strobes
    step(1, 0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(1, 0));
      step(1, s, $urandom, 0);
    end

    // D=MAX_DELAY with wrap
    step(1, 0, '0, MAXD);
    for (int i = 0; i < 130; i++) step(1, 1, $urandom, MAXD);

    // Overrange request clamps and sets the sticky error
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 100);
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(1, 0));
      step(1, s, $urandom, 5);
    end
    check("delay_err_sticky", DW'(delay_err), DW'(1));

    // Delay change 8 -> 4 mid-stream
    step(1, 0, '0, 8);
    for (int i = 0; i < 20; i++) step(1, 1, $urandom, 8);
    for (int i = 0; i < 20; i++) step(1, 1, $urandom, 4);

    // Enable low with strobes high
    for (int i = 0; i < 10; i++) step(1, 1, $urandom, 4);
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 4);
    for (int i = 0; i < 10; i++) step(1, 1, $urandom, 4);

    // Random traffic with occasional delay changes
    dr = 4;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(19, 0) == 0) dr = $urandom_range(70, 0);
      s = 1'($urandom_range(3, 0) != 0);
      r = $urandom;
      step(1'($urandom_range(9, 0) != 0), s, r, dr);
    end

    // Asynchronous reset mid-stream
    step(1, 0, '0, 6);
    for (int i = 0; i < 10; i++) step(1, 1, $urandom, 6);
    reset = 1'b1;
    #1;
    check("async_rst_data_out", data_out, '0);
    check("async_rst_strobe", DW'(output_strobe), '0);
    check("async_rst_primed", DW'(primed), DW'(1));
    check("async_rst_delay_err", DW'(delay_err), '0);
    model_reset();
    step(1, 1, $urandom, 6);
    step(1, 1, $urandom, 6);
    reset = 1'b0;
    step(1, 0, '0, 6);
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(3, 0) != 0);
      step(1, s, $urandom, 6);
    end

    for (int i = 0; i < 3; i++) step(1, 0, '0, 6);
    check("queue_drained", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
